// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access sequencer for the RV32I core.
// Accepts a load/store from the ALU stage, checks FUNCT3 and alignment,
// issues a single-outstanding MEM_REQ/MEM_ACK transaction and returns the
// sign/zero-extended load result.
// Build option: define LSU_TIMEOUT_EN to abandon a request after WAIT_MAX
// cycles without MEM_ACK (ERR_CODE=10). Without it REQ waits indefinitely.
// Handshake: MEM_REQ is held high with all MEM_* outputs stable until a cycle
// in which MEM_ACK=1 is sampled; that edge completes the transfer. MEM_ACK
// outside REQ is ignored. START is only sampled while BUSY=0.
module load_store_unit #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        START,
   input  logic [6:0]  OPCODE,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] ADDR,
   input  logic [31:0] STORE_DATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [1:0]  ERR_CODE,
   output logic [31:0] LOAD_DATA,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [3:0]  MEM_BE,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK,
   output logic [1:0]  DBG_STATE
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_busy;
   logic        r_done;
   logic [1:0]  r_err;
   logic [31:0] r_load_data;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_MAX - 1);
   logic [7:0]  r_wait_cnt;
`else
   logic        w_unused_cfg;
   assign w_unused_cfg = ^8'(WAIT_MAX);
`endif

   logic        w_is_load;
   logic        w_is_store;
   logic        w_valid_op;
   logic        w_f3_legal;
   logic        w_misaligned;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_rd_byte;
   logic [15:0] w_rd_half;
   logic [31:0] w_load_ext;

   assign w_is_load  = (OPCODE == OP_LOAD);
   assign w_is_store = (OPCODE == OP_STORE);
   assign w_valid_op = w_is_load | w_is_store;

   // Decode FUNCT3 legality, alignment, byte enables and replicated store data
   always_comb begin
      w_f3_legal   = 1'b0;
      w_misaligned = 1'b0;
      w_be         = 4'b0000;
      w_wdata      = 32'h0;
      case (FUNCT3)
         3'b000:  w_f3_legal = 1'b1;
         3'b001:  w_f3_legal = 1'b1;
         3'b010:  w_f3_legal = 1'b1;
         3'b100:  w_f3_legal = w_is_load;
         3'b101:  w_f3_legal = w_is_load;
         default: w_f3_legal = 1'b0;
      endcase
      case (FUNCT3[1:0])
         2'b01:   w_misaligned = ADDR[0];
         2'b10:   w_misaligned = (ADDR[1:0] != 2'b00);
         default: w_misaligned = 1'b0;
      endcase
      if (w_is_store) begin
         case (FUNCT3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << ADDR[1:0];
               w_wdata = {4{STORE_DATA[7:0]}};
            end
            2'b01: begin
               w_be    = 4'b0011 << {ADDR[1], 1'b0};
               w_wdata = {2{STORE_DATA[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = STORE_DATA;
            end
         endcase
      end
   end

   // Extract and extend the load lane using the offset/width latched at issue
   always_comb begin
      w_rd_byte  = MEM_RDATA[8*r_off +: 8];
      w_rd_half  = MEM_RDATA[16*r_off[1] +: 16];
      w_load_ext = MEM_RDATA;
      case (r_funct3)
         3'b000:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
         3'b001:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
         3'b100:  w_load_ext = {24'h0, w_rd_byte};
         3'b101:  w_load_ext = {16'h0, w_rd_half};
         default: w_load_ext = MEM_RDATA;
      endcase
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 2'b00;
         r_load_data <= 32'h0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'h0;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
         r_wait_cnt  <= 8'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (START && w_valid_op) begin
                  r_busy <= 1'b1;
                  if (!w_f3_legal) begin
                     r_state <= ST_RESP;
                     r_done  <= 1'b1;
                     r_err   <= 2'b11;
                  end else if (w_misaligned) begin
                     r_state <= ST_RESP;
                     r_done  <= 1'b1;
                     r_err   <= 2'b01;
                  end else begin
                     r_state     <= ST_REQ;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= w_is_store;
                     r_mem_addr  <= {ADDR[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                     r_funct3    <= FUNCT3;
                     r_off       <= ADDR[1:0];
`ifdef LSU_TIMEOUT_EN
                     r_wait_cnt  <= 8'd0;
`endif
                  end
               end
            end
            ST_REQ: begin
               if (MEM_ACK) begin
                  r_state   <= ST_RESP;
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 2'b00;
                  if (!r_mem_we) begin
                     r_load_data <= w_load_ext;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (r_wait_cnt == LP_WAIT_LAST) begin
                  r_state   <= ST_RESP;
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 2'b10;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
`endif
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_done    <= 1'b0;
               r_busy    <= 1'b0;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign ERR_CODE  = r_err;
   assign LOAD_DATA = r_load_data;
   assign MEM_REQ   = r_mem_req;
   assign MEM_WE    = r_mem_we;
   assign MEM_ADDR  = r_mem_addr;
   assign MEM_BE    = r_mem_be;
   assign MEM_WDATA = r_mem_wdata;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// plus hand-written sequences for reset, ignored START, back-to-back issue,
// reset mid-request and the request timeout (LSU_TIMEOUT_EN builds).
module tb_load_store_unit;

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   logic        clk = 1'b0;
   logic        reset;
   logic        START;
   logic [6:0]  OPCODE;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDR;
   logic [31:0] STORE_DATA;
   logic        BUSY;
   logic        DONE;
   logic [1:0]  ERR_CODE;
   logic [31:0] LOAD_DATA;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [31:0] MEM_ADDR;
   logic [3:0]  MEM_BE;
   logic [31:0] MEM_WDATA;
   logic [31:0] MEM_RDATA;
   logic        MEM_ACK;
   logic [1:0]  DBG_STATE;

   int n_vec  = 0;
   int n_fail = 0;
   logic [31:0] exp_ld;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          waits;
      logic [1:0]  err;
      logic [31:0] ld;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs[14];

   load_store_unit #(.WAIT_MAX(4)) dut (
      .clk(clk), .reset(reset), .START(START), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
      .ADDR(ADDR), .STORE_DATA(STORE_DATA), .BUSY(BUSY), .DONE(DONE),
      .ERR_CODE(ERR_CODE), .LOAD_DATA(LOAD_DATA), .MEM_REQ(MEM_REQ),
      .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
      .DBG_STATE(DBG_STATE)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, " busy"}, 32'(BUSY), 32'd0);
      check({tag, " done"}, 32'(DONE), 32'd0);
      check({tag, " err"}, 32'(ERR_CODE), 32'd0);
      check({tag, " load"}, LOAD_DATA, 32'h0);
      check({tag, " req"}, 32'(MEM_REQ), 32'd0);
      check({tag, " we"}, 32'(MEM_WE), 32'd0);
      check({tag, " maddr"}, MEM_ADDR, 32'h0);
      check({tag, " be"}, 32'(MEM_BE), 32'd0);
      check({tag, " wdata"}, MEM_WDATA, 32'h0);
      check({tag, " state"}, 32'(DBG_STATE), 32'd0);
   endtask

   // One transaction: START in cycle 0, checks from cycle 1 until after DONE
   task automatic run_vec(input vec_t v, input int idx);
      string t;
      bit    is_st;
      bit    bad;
      t     = $sformatf("v%0d", idx);
      is_st = (v.op == OP_ST);
      bad   = (v.err != 2'b00);
      START = 1'b1; OPCODE = v.op; FUNCT3 = v.f3; ADDR = v.addr; STORE_DATA = v.sdata;
      if (bad) begin
         MEM_ACK = 1'b1; MEM_RDATA = 32'h5A5A_5A5A;
      end
      tick();
      START = 1'b0; MEM_ACK = 1'b0; ADDR = ~v.addr; STORE_DATA = ~v.sdata;
      if (bad) begin
         check({t, " err done"}, 32'(DONE), 32'd1);
         check({t, " err busy"}, 32'(BUSY), 32'd1);
         check({t, " err code"}, 32'(ERR_CODE), 32'(v.err));
         check({t, " err req"}, 32'(MEM_REQ), 32'd0);
         check({t, " err load"}, LOAD_DATA, exp_ld);
      end else begin
         check({t, " req"}, 32'(MEM_REQ), 32'd1);
         check({t, " we"}, 32'(MEM_WE), 32'(is_st));
         check({t, " maddr"}, MEM_ADDR, v.maddr);
         check({t, " be"}, 32'(MEM_BE), 32'(v.be));
         if (is_st) check({t, " wdata"}, MEM_WDATA, v.wdata);
         for (int w = 0; w < v.waits; w++) begin
            MEM_RDATA = ~v.rdata;
            tick();
            check({t, " wait req"}, 32'(MEM_REQ), 32'd1);
            check({t, " wait maddr"}, MEM_ADDR, v.maddr);
            check({t, " wait done"}, 32'(DONE), 32'd0);
         end
         MEM_ACK = 1'b1; MEM_RDATA = v.rdata;
         tick();
         MEM_ACK = 1'b0; MEM_RDATA = ~v.rdata;
         if (!is_st) exp_ld = v.ld;
         check({t, " done"}, 32'(DONE), 32'd1);
         check({t, " code"}, 32'(ERR_CODE), 32'd0);
         check({t, " load"}, LOAD_DATA, exp_ld);
         check({t, " req drop"}, 32'(MEM_REQ), 32'd0);
         check({t, " state resp"}, 32'(DBG_STATE), 32'd2);
      end
      tick();
      check({t, " post done"}, 32'(DONE), 32'd0);
      check({t, " post busy"}, 32'(BUSY), 32'd0);
      check({t, " post err hold"}, 32'(ERR_CODE), 32'(v.err));
   endtask

   initial begin
      // op, f3, addr, sdata, rdata, waits, err, ld, maddr, be, wdata
      vecs[0]  = '{OP_LD, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 2'b00, 32'hFFFF_FF80, 32'h0000_1000, 4'b0000, 32'h0};
      vecs[1]  = '{OP_LD, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 3, 2'b00, 32'h0000_BEEF, 32'h0000_2000, 4'b0000, 32'h0};
      vecs[2]  = '{OP_ST, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0, 1, 2'b00, 32'h0, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB};
      vecs[3]  = '{OP_ST, 3'b010, 32'h0000_4002, 32'h1111_2222, 32'h0, 0, 2'b01, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[4]  = '{OP_LD, 3'b011, 32'h0000_5000, 32'h0, 32'h0, 0, 2'b11, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[5]  = '{OP_LD, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 2, 2'b00, 32'hFFFF_8001, 32'h0000_6000, 4'b0000, 32'h0};
      vecs[6]  = '{OP_LD, 3'b010, 32'h0000_7004, 32'h0, 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, 32'h0000_7004, 4'b0000, 32'h0};
      vecs[7]  = '{OP_LD, 3'b100, 32'h0000_8001, 32'h0, 32'h1122_F344, 0, 2'b00, 32'h0000_00F3, 32'h0000_8000, 4'b0000, 32'h0};
      vecs[8]  = '{OP_ST, 3'b001, 32'h0000_9002, 32'hAAAA_5A5B, 32'h0, 0, 2'b00, 32'h0, 32'h0000_9000, 4'b1100, 32'h5A5B_5A5B};
      vecs[9]  = '{OP_ST, 3'b010, 32'h0000_A000, 32'hCAFE_F00D, 32'h0, 2, 2'b00, 32'h0, 32'h0000_A000, 4'b1111, 32'hCAFE_F00D};
      vecs[10] = '{OP_LD, 3'b001, 32'h0000_B001, 32'h0, 32'h0, 0, 2'b01, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[11] = '{OP_ST, 3'b011, 32'h0000_C001, 32'h0, 32'h0, 0, 2'b11, 32'h0, 32'h0, 4'b0000, 32'h0};
      vecs[12] = '{OP_LD, 3'b000, 32'h0000_D000, 32'h0, 32'h0000_007F, 1, 2'b00, 32'h0000_007F, 32'h0000_D000, 4'b0000, 32'h0};
      vecs[13] = '{OP_ST, 3'b000, 32'h0000_E003, 32'h0000_00C3, 32'h0, 0, 2'b00, 32'h0, 32'h0000_E000, 4'b1000, 32'hC3C3_C3C3};

      // Clock/reset
      reset = 1'b1; START = 1'b0; OPCODE = '0; FUNCT3 = '0; ADDR = '0;
      STORE_DATA = '0; MEM_RDATA = '0; MEM_ACK = 1'b0;
      exp_ld = 32'h0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check_idle_reset("reset");

      // START with a non-memory opcode is ignored
      START = 1'b1; OPCODE = 7'b0110011; FUNCT3 = 3'b000; ADDR = 32'h40;
      tick();
      START = 1'b0;
      check("bad op busy", 32'(BUSY), 32'd0);
      check("bad op req", 32'(MEM_REQ), 32'd0);
      tick();
      check("bad op done", 32'(DONE), 32'd0);

      // Table-driven single transactions
      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // START held through a busy SW is ignored, then accepted right after DONE
      START = 1'b1; OPCODE = OP_ST; FUNCT3 = 3'b010; ADDR = 32'h0000_F000; STORE_DATA = 32'h0102_0304;
      tick();
      OPCODE = OP_LD; FUNCT3 = 3'b000; ADDR = 32'h0000_0010; STORE_DATA = 32'hFFFF_FFFF;
      check("b2b req", 32'(MEM_REQ), 32'd1);
      tick();
      check("b2b hold maddr", MEM_ADDR, 32'h0000_F000);
      check("b2b hold be", 32'(MEM_BE), 32'hF);
      check("b2b hold wdata", MEM_WDATA, 32'h0102_0304);
      check("b2b hold we", 32'(MEM_WE), 32'd1);
      MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_00A5;
      tick();
      MEM_ACK = 1'b0;
      check("b2b done", 32'(DONE), 32'd1);
      check("b2b load unchanged", LOAD_DATA, exp_ld);
      tick();
      check("b2b no 2nd done", 32'(DONE), 32'd0);
      check("b2b idle busy", 32'(BUSY), 32'd0);
      tick();
      START = 1'b0;
      check("b2b new req", 32'(MEM_REQ), 32'd1);
      check("b2b new maddr", MEM_ADDR, 32'h0000_0010);
      check("b2b new we", 32'(MEM_WE), 32'd0);
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      exp_ld = 32'hFFFF_FFA5;
      check("b2b new done", 32'(DONE), 32'd1);
      check("b2b new load", LOAD_DATA, exp_ld);
      tick();

      // Reset in the 2nd REQ cycle of an LW abandons the request
      START = 1'b1; OPCODE = OP_LD; FUNCT3 = 3'b010; ADDR = 32'h0000_0200;
      tick();
      START = 1'b0;
      check("rst lw req", 32'(MEM_REQ), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_ld = 32'h0;
      check_idle_reset("rst mid");
      for (int c = 0; c < 3; c++) begin
         MEM_ACK = 1'b1; MEM_RDATA = 32'h7777_7777;
         tick();
         check("rst no done", 32'(DONE), 32'd0);
      end
      MEM_ACK = 1'b0;
      START = 1'b1; OPCODE = OP_LD; FUNCT3 = 3'b010; ADDR = 32'h0000_0300;
      tick();
      START = 1'b0;
      check("rst new req", 32'(MEM_REQ), 32'd1);
      MEM_ACK = 1'b1; MEM_RDATA = 32'h0BAD_F00D;
      tick();
      MEM_ACK = 1'b0;
      exp_ld = 32'h0BAD_F00D;
      check("rst new done", 32'(DONE), 32'd1);
      check("rst new load", LOAD_DATA, exp_ld);
      tick();

      // Request with no ACK
      START = 1'b1; OPCODE = OP_LD; FUNCT3 = 3'b010; ADDR = 32'h0000_0100;
      tick();
      START = 1'b0;
`ifdef LSU_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         check("to req high", 32'(MEM_REQ), 32'd1);
         check("to no done", 32'(DONE), 32'd0);
         tick();
      end
      check("to done", 32'(DONE), 32'd1);
      check("to code", 32'(ERR_CODE), 32'd2);
      check("to req drop", 32'(MEM_REQ), 32'd0);
      check("to load unchanged", LOAD_DATA, exp_ld);
      tick();
      check("to post done", 32'(DONE), 32'd0);
      check("to post busy", 32'(BUSY), 32'd0);
`else
      for (int c = 1; c <= 20; c++) begin
         check("nto req high", 32'(MEM_REQ), 32'd1);
         check("nto no done", 32'(DONE), 32'd0);
         tick();
      end
      MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
      tick();
      MEM_ACK = 1'b0;
      exp_ld = 32'h1234_5678;
      check("nto done", 32'(DONE), 32'd1);
      check("nto code", 32'(ERR_CODE), 32'd0);
      check("nto load", LOAD_DATA, exp_ld);
      tick();
      check("nto post busy", 32'(BUSY), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
